// File: rtl/fir_coe_pkg.sv
// Shared types and constants for the FIR coefficient reload sender.
package fir_coe_pkg;

  localparam int unsigned GAP_W = 4;

  typedef logic [1:0] coe_state_t;

  localparam coe_state_t ST_IDLE = 2'd0;
  localparam coe_state_t ST_SEND = 2'd1;
  localparam coe_state_t ST_GAP  = 2'd2;
  localparam coe_state_t ST_LOAD = 2'd3;

  // Address width for an n-entry bank; never narrower than one bit.
  function automatic int unsigned coe_aw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_coe_sender_if.sv
// Host write port plus coefficient reload stream of one fir_coe_sender.
interface fir_coe_sender_if #(
  parameter int unsigned COE_WDTH = 29,
  parameter int unsigned AW       = 5
);
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [COE_WDTH-1:0] wr_data;
  logic                start;
  logic                busy;
  logic                done;
  logic                wr_drop;
  logic                coe_sop;
  logic                coe_vld;
  logic [COE_WDTH-1:0] coe_din;
  logic                coe_load;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  busy, done, wr_drop, coe_sop, coe_vld, coe_din, coe_load
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output busy, done, wr_drop, coe_sop, coe_vld, coe_din, coe_load
  );
endinterface

// File: rtl/fir_coe_bank.sv
// Coefficient register file: one write port, one combinational read port.
module fir_coe_bank #(
  parameter int unsigned DEPTH = 26,
  parameter int unsigned WDTH  = 29,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [WDTH-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [WDTH-1:0] rdata_c
);

  logic [WDTH-1:0] mem_q [DEPTH];
  logic [WDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < DEPTH)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range indices read as zero rather than aliasing.
  always_comb begin
    rdata_c = '0;
    if (32'(raddr) < DEPTH) begin
      rdata_c = mem_q[raddr];
    end
  end

endmodule

// File: rtl/fir_coe_sender.sv
// Stores a half-filter coefficient set and serialises it onto the reload stream.
module fir_coe_sender
  import fir_coe_pkg::*;
#(
  parameter int unsigned COE_NUM      = 51,
  parameter int unsigned COE_WDTH     = 29,
  parameter int unsigned COE_NUM_HALF = (COE_NUM + 1) / 2,
  parameter int unsigned GAP_CYC      = 0,
  parameter int unsigned AW           = coe_aw(COE_NUM_HALF)
) (
  input  logic              cfg_clk,
  input  logic              cfg_rst,
  fir_coe_sender_if.slave   bus
);

  localparam logic [AW-1:0]    IDX_LAST = AW'(COE_NUM_HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  coe_state_t          state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_drop_q, wr_drop_d;
  logic                sop_q, sop_d;
  logic                vld_q, vld_d;
  logic                load_q, load_d;
  logic [COE_WDTH-1:0] din_q, din_d;

  logic                wr_ok_c;
  logic [COE_WDTH-1:0] rd_c;

  // Writes land only while idle and in range; everything else is dropped.
  always_comb begin
    wr_ok_c = bus.wr_en && (state_q == ST_IDLE) && (32'(bus.wr_addr) < COE_NUM_HALF);
  end

  fir_coe_bank #(
    .DEPTH (COE_NUM_HALF),
    .WDTH  (COE_WDTH),
    .AW    (AW)
  ) u_bank (
    .clk     (cfg_clk),
    .rst     (cfg_rst),
    .we      (wr_ok_c),
    .waddr   (bus.wr_addr),
    .wdata   (bus.wr_data),
    .raddr   (idx_d),
    .rdata_c (rd_c)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    din_d     = din_q;
    wr_drop_d = bus.wr_en && !wr_ok_c;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_LOAD;
        end else begin
          idx_d = idx_q + AW'(1);
          if (GAP_CYC != 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    vld_d  = (state_d == ST_SEND);
    sop_d  = vld_d && (state_q == ST_IDLE);
    load_d = (state_d == ST_LOAD);
    done_d = load_d;
    busy_d = (state_d != ST_IDLE);

    // A write accepted together with start must reach the very first word.
    if (vld_d) begin
      din_d = (wr_ok_c && (bus.wr_addr == idx_d)) ? bus.wr_data : rd_c;
    end
  end

  always_ff @(posedge cfg_clk) begin
    if (cfg_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      sop_q     <= 1'b0;
      vld_q     <= 1'b0;
      load_q    <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
      sop_q     <= sop_d;
      vld_q     <= vld_d;
      load_q    <= load_d;
      din_q     <= din_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_drop  = wr_drop_q;
  assign bus.coe_sop  = sop_q;
  assign bus.coe_vld  = vld_q;
  assign bus.coe_din  = din_q;
  assign bus.coe_load = load_q;

endmodule

// File: tb/tb_fir_coe_sender.sv
// Directed bench for fir_coe_sender: two instances (GAP_CYC 0 and 2) share stimulus.
module tb_fir_coe_sender;
  import fir_coe_pkg::*;

  localparam int unsigned N   = 26;
  localparam int unsigned W   = 29;
  localparam int unsigned AWT = 5;
  localparam int          WIN = 80;

  logic clk = 1'b0;
  logic rst;
  logic wr_en, start;
  logic [AWT-1:0] wr_addr;
  logic [W-1:0]   wr_data;

  always #5 clk = ~clk;

  fir_coe_sender_if #(.COE_WDTH(W), .AW(AWT)) bus0 ();
  fir_coe_sender_if #(.COE_WDTH(W), .AW(AWT)) bus2 ();

  assign bus0.wr_en   = wr_en;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus0.start   = start;
  assign bus2.wr_en   = wr_en;
  assign bus2.wr_addr = wr_addr;
  assign bus2.wr_data = wr_data;
  assign bus2.start   = start;

  fir_coe_sender #(.COE_NUM(51), .COE_WDTH(W), .GAP_CYC(0)) dut0 (
    .cfg_clk (clk), .cfg_rst (rst), .bus (bus0)
  );
  fir_coe_sender #(.COE_NUM(51), .COE_WDTH(W), .GAP_CYC(2)) dut2 (
    .cfg_clk (clk), .cfg_rst (rst), .bus (bus2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] bank_m [N];

  typedef struct {
    logic           en;
    logic [AWT-1:0] addr;
    logic [W-1:0]   data;
    logic           exp_drop;
  } wvec_t;

  wvec_t tbl [6];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s d=%0d got=%0h want=%0h", name, d, act, exp);
    end
  endtask

  // Expected outputs come from the documented timeline: word k at d = 1 + k*(GAP+1).
  task automatic check_dut(input int g, input int d, input bit inj, input int rst_at);
    logic a_busy, a_done, a_drop, a_sop, a_vld, a_load;
    logic [W-1:0] a_din;
    int gp, last_d, k;
    bit eb, ev, es, el, ed;
    if (g == 0) begin
      a_busy = bus0.busy; a_done = bus0.done; a_drop = bus0.wr_drop;
      a_sop = bus0.coe_sop; a_vld = bus0.coe_vld; a_load = bus0.coe_load; a_din = bus0.coe_din;
      gp = 1;
    end else begin
      a_busy = bus2.busy; a_done = bus2.done; a_drop = bus2.wr_drop;
      a_sop = bus2.coe_sop; a_vld = bus2.coe_vld; a_load = bus2.coe_load; a_din = bus2.coe_din;
      gp = 3;
    end
    last_d = 1 + (int'(N) - 1) * gp + 1;
    k  = (d >= 1) ? (d - 1) / gp : 0;
    eb = (d >= 1) && (d <= last_d);
    ev = (d >= 1) && ((d - 1) % gp == 0) && (k < int'(N));
    es = (d == 1);
    el = (d == last_d);
    ed = inj && (d == 6);
    if (rst_at > 0 && d > rst_at) begin
      eb = 0; ev = 0; es = 0; el = 0; ed = 0;
    end
    chk($sformatf("g%0d busy", g * 2), d, 32'(a_busy), 32'(eb));
    chk($sformatf("g%0d coe_vld", g * 2), d, 32'(a_vld), 32'(ev));
    chk($sformatf("g%0d coe_sop", g * 2), d, 32'(a_sop), 32'(es));
    chk($sformatf("g%0d coe_load", g * 2), d, 32'(a_load), 32'(el));
    chk($sformatf("g%0d done", g * 2), d, 32'(a_done), 32'(el));
    chk($sformatf("g%0d wr_drop", g * 2), d, 32'(a_drop), 32'(ed));
    if (ev) chk($sformatf("g%0d coe_din[%0d]", g * 2, k), d, 32'(a_din), 32'(bank_m[k]));
    if (rst_at > 0 && d > rst_at) chk($sformatf("g%0d coe_din_rst", g * 2), d, 32'(a_din), 32'd0);
  endtask

  // One transmission window; start is raised in the current cycle.
  task automatic send_window(input bit inj, input bit same_wr, input int rst_at);
    int bc0 = 0, bc2 = 0, sc0 = 0, sc2 = 0, lc0 = 0, lc2 = 0;
    int eb0, eb2;
    start = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = AWT'(5); wr_data = W'(7777);
      bank_m[5] = W'(7777);
    end
    for (int d = 1; d <= WIN; d++) begin
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      if (rst_at > 0 && d == rst_at + 1) rst = 1'b0;
      check_dut(0, d, inj, rst_at);
      check_dut(1, d, inj, rst_at);
      bc0 += int'(bus0.busy);     bc2 += int'(bus2.busy);
      sc0 += int'(bus0.coe_sop);  sc2 += int'(bus2.coe_sop);
      lc0 += int'(bus0.coe_load); lc2 += int'(bus2.coe_load);
      if (inj && d == 3) start = 1'b1;
      if (inj && d == 5) begin
        wr_en = 1'b1; wr_addr = AWT'(3); wr_data = W'(999);
      end
      if (rst_at > 0 && d == rst_at) begin
        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) bank_m[i] = '0;
      end
    end
    eb0 = (rst_at > 0) ? rst_at : 27;
    eb2 = (rst_at > 0) ? rst_at : 77;
    chk("g0 busy_cycles", 0, 32'(bc0), 32'(eb0));
    chk("g2 busy_cycles", 0, 32'(bc2), 32'(eb2));
    chk("g0 sop_count", 0, 32'(sc0), 32'd1);
    chk("g2 sop_count", 0, 32'(sc2), 32'd1);
    chk("g0 load_count", 0, 32'(lc0), (rst_at > 0) ? 32'd0 : 32'd1);
    chk("g2 load_count", 0, 32'(lc2), (rst_at > 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < int'(N); i++) bank_m[i] = '0;

    tbl[0] = '{1'b1, 5'd0,  29'd100, 1'b0};
    tbl[1] = '{1'b1, 5'd26, 29'd55,  1'b1};
    tbl[2] = '{1'b1, 5'd31, 29'd77,  1'b1};
    tbl[3] = '{1'b1, 5'd25, 29'd125, 1'b0};
    tbl[4] = '{1'b0, 5'd30, 29'd1,   1'b0};
    tbl[5] = '{1'b1, 5'd13, 29'd113, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_dut(0, 0, 1'b0, 0);
    check_dut(1, 0, 1'b0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty bank after reset: every word zero.
    send_window(1'b0, 1'b0, 0);

    foreach (tbl[i]) begin
      wr_en = tbl[i].en; wr_addr = tbl[i].addr; wr_data = tbl[i].data;
      @(posedge clk); #1;
      wr_en = 1'b0;
      chk($sformatf("tbl%0d g0 wr_drop", i), i, 32'(bus0.wr_drop), 32'(tbl[i].exp_drop));
      chk($sformatf("tbl%0d g2 wr_drop", i), i, 32'(bus2.wr_drop), 32'(tbl[i].exp_drop));
      chk($sformatf("tbl%0d g0 busy", i), i, 32'(bus0.busy), 32'd0);
      if (tbl[i].en && !tbl[i].exp_drop) bank_m[tbl[i].addr] = tbl[i].data;
    end

    for (int i = 0; i < int'(N); i++) begin
      wr_en = 1'b1; wr_addr = AWT'(i); wr_data = W'(i + 100);
      @(posedge clk); #1;
      wr_en = 1'b0;
      chk("fill g0 wr_drop", i, 32'(bus0.wr_drop), 32'd0);
      bank_m[i] = W'(i + 100);
    end

    // Full set, with a repeated start at d=3 and a rejected write at d=5.
    send_window(1'b1, 1'b0, 0);
    // Write and start in the same idle cycle; word 5 must carry the new value.
    send_window(1'b0, 1'b1, 0);
    // Reset while word 10 of the gapless instance is on the bus.
    send_window(1'b0, 1'b0, 11);
    // Bank was cleared by reset.
    send_window(1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
